// File: rtl/pad_share_pkg.sv
// Shared types and defaults for the user-pad sharing arbiter.
package pad_share_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_TURN  = 2'd2
  } state_e;

  localparam int unsigned TA_CYCLES_DEFAULT = 2;

endpackage

// File: rtl/pad_share_rr_pick.sv
// Combinational round-robin select: first set request at or after ptr, wrapping.
module pad_share_rr_pick
  import pad_share_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic               valid,
  output logic [IW-1:0]      idx
);

  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      int unsigned c;
      c = (32'(ptr) + k) % NUM_REQ;
      if (!valid && req[c]) begin
        valid = 1'b1;
        idx   = IW'(c);
      end
    end
  end

endmodule

// File: rtl/pad_share_arbiter.sv
// Level request/grant arbiter for a shared pad bank, with a forced all-input
// turnaround window between owners.
module pad_share_arbiter
  import pad_share_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned NUM_PADS  = 8,
  parameter int unsigned TA_CYCLES = TA_CYCLES_DEFAULT
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_i,
  input  logic [NUM_REQ*NUM_PADS-1:0]  out_i,
  input  logic [NUM_REQ*NUM_PADS-1:0]  oen_i,
  output logic [NUM_REQ-1:0]           grant_o,
  output logic [$clog2(NUM_REQ)-1:0]   owner_o,
  output logic                         busy_o,
  output logic [NUM_PADS-1:0]          pad_out_o,
  output logic [NUM_PADS-1:0]          pad_oen_o
);

  localparam int unsigned IW = $clog2(NUM_REQ);
  localparam int unsigned CW = $clog2(TA_CYCLES + 1);

  state_e        state_q, state_d;
  logic [IW-1:0] owner_q, owner_d;
  logic [IW-1:0] ptr_q,   ptr_d;
  logic [CW-1:0] cnt_q,   cnt_d;

  logic          pick_valid;
  logic [IW-1:0] pick_idx;

  pad_share_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_rr_pick (
    .req   (req_i),
    .ptr   (ptr_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          state_d = ST_GRANT;
          owner_d = pick_idx;
          ptr_d   = (pick_idx == IW'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
        end
      end
      ST_GRANT: begin
        // Only the owner's own release ends the grant; nobody pre-empts.
        if (!req_i[owner_q]) begin
          state_d = ST_TURN;
          cnt_d   = CW'(TA_CYCLES - 1);
        end
      end
      ST_TURN: begin
        if (cnt_q == '0) state_d = ST_IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Pads follow registered state only; out_i/oen_i pass through the owner mux.
  always_comb begin
    grant_o   = '0;
    pad_out_o = '0;
    pad_oen_o = '1;
    if (state_q == ST_GRANT) begin
      for (int unsigned r = 0; r < NUM_REQ; r++) begin
        if (owner_q == IW'(r)) begin
          grant_o[r] = 1'b1;
          pad_out_o  = out_i[r*NUM_PADS +: NUM_PADS];
          pad_oen_o  = oen_i[r*NUM_PADS +: NUM_PADS];
        end
      end
    end
  end

  assign owner_o = owner_q;
  assign busy_o  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_pad_share_arbiter.sv
// Directed scoreboard bench for pad_share_arbiter (NUM_REQ=4, NUM_PADS=8, TA_CYCLES=2).
module tb_pad_share_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_i;
  logic [31:0] out_i;
  logic [31:0] oen_i;
  logic [3:0]  grant_o;
  logic [1:0]  owner_o;
  logic        busy_o;
  logic [7:0]  pad_out_o;
  logic [7:0]  pad_oen_o;

  always #5 clk = ~clk;

  pad_share_arbiter #(
    .NUM_REQ   (4),
    .NUM_PADS  (8),
    .TA_CYCLES (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_i     (req_i),
    .out_i     (out_i),
    .oen_i     (oen_i),
    .grant_o   (grant_o),
    .owner_o   (owner_o),
    .busy_o    (busy_o),
    .pad_out_o (pad_out_o),
    .pad_oen_o (pad_oen_o)
  );

  typedef struct packed {
    logic [3:0] grant;
    logic [7:0] out;
    logic [7:0] oen;
    logic [1:0] owner;
    logic       busy;
  } exp_t;

  logic [7:0] out_tbl [4];
  logic [7:0] oen_tbl [4];

  exp_t  exp_q  [$];
  string name_q [$];
  int    checks = 0;
  int    errors = 0;

  // Drive one cycle of stimulus and queue what the DUT must show after the edge.
  task automatic step(input logic r, input logic [3:0] rq, input string nm,
                      input logic bsy, input logic gr, input int own);
    exp_t e;
    rst   = r;
    req_i = rq;
    e.grant = gr ? (4'b0001 << own) : 4'b0000;
    e.out   = gr ? out_tbl[own] : 8'h00;
    e.oen   = gr ? oen_tbl[own] : 8'hFF;
    e.owner = 2'(own);
    e.busy  = bsy;
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge clk);
    @(negedge clk);
  endtask

  // Release/turnaround/idle sequence after an owner drops its request at this edge.
  task automatic release_seq(input logic [3:0] drop_req, input logic [3:0] ta_req,
                             input int own, input string nm);
    step(1'b0, drop_req, {nm, "_turn1"}, 1'b1, 1'b0, own);
    step(1'b0, ta_req,   {nm, "_turn2"}, 1'b1, 1'b0, own);
    step(1'b0, ta_req,   {nm, "_idle"},  1'b0, 1'b0, own);
  endtask

  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_t  e;
      exp_t  a;
      string nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      a  = '{grant: grant_o, out: pad_out_o, oen: pad_oen_o, owner: owner_o, busy: busy_o};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL %s: got grant=%b out=%h oen=%h owner=%0d busy=%b, want grant=%b out=%h oen=%h owner=%0d busy=%b",
                 nm, a.grant, a.out, a.oen, a.owner, a.busy,
                 e.grant, e.out, e.oen, e.owner, e.busy);
      end
    end
  end

  initial begin
    out_tbl = '{8'hA5, 8'h5A, 8'h3C, 8'hC3};
    oen_tbl = '{8'hF0, 8'h0F, 8'h00, 8'h55};
    out_i   = {8'hC3, 8'h3C, 8'h5A, 8'hA5};
    oen_i   = {8'h55, 8'h00, 8'h0F, 8'hF0};
    rst     = 1'b1;
    req_i   = 4'hF;

    // Reset held two cycles with all requests high.
    step(1'b1, 4'hF, "rst0", 1'b0, 1'b0, 0);
    step(1'b1, 4'hF, "rst1", 1'b0, 1'b0, 0);
    step(1'b0, 4'hF, "post_rst_grant0", 1'b1, 1'b1, 0);
    release_seq(4'h0, 4'h0, 0, "rel0");

    // Single owner, then hand-off to requester 2 through the turnaround.
    step(1'b0, 4'b0010, "single_owner1", 1'b1, 1'b1, 1);
    step(1'b0, 4'b0110, "hold1",         1'b1, 1'b1, 1);
    release_seq(4'b0100, 4'b0100, 1, "ta1");
    step(1'b0, 4'b0100, "ta_grant2",     1'b1, 1'b1, 2);

    // Reset during GRANT of owner 2; pointer must restart at 0.
    step(1'b1, 4'b0100, "rst_mid",       1'b0, 1'b0, 0);
    step(1'b0, 4'b1001, "rst_ptr_grant0",1'b1, 1'b1, 0);

    // Round-robin rotation: 0 -> 1 -> 2 -> 3 -> 0.
    release_seq(4'b1110, 4'b1111, 0, "rr_a");
    step(1'b0, 4'b1111, "rr_grant1", 1'b1, 1'b1, 1);
    release_seq(4'b1101, 4'b1111, 1, "rr_b");
    step(1'b0, 4'b1111, "rr_grant2", 1'b1, 1'b1, 2);
    release_seq(4'b1011, 4'b1111, 2, "rr_c");
    step(1'b0, 4'b1111, "rr_grant3", 1'b1, 1'b1, 3);
    release_seq(4'b0111, 4'b1111, 3, "rr_d");
    step(1'b0, 4'b1111, "rr_grant0", 1'b1, 1'b1, 0);

    // No pre-emption: owner 0 holds 20 cycles against requests 1..3.
    for (int i = 0; i < 20; i++) step(1'b0, 4'b1111, "hold0", 1'b1, 1'b1, 0);

    // Requests 1..3 rising during TURN wait until IDLE.
    release_seq(4'b0000, 4'b1110, 0, "late");
    step(1'b0, 4'b1110, "late_grant1", 1'b1, 1'b1, 1);

    step(1'b0, 4'b1110, "final_hold1", 1'b1, 1'b1, 1);
    @(posedge clk);
    @(negedge clk);
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no end of stimulus by 100000, want finish");
    $fatal(1, "timeout");
  end

endmodule
